// File: rtl/adc_pkg.sv
// Shared constants for the ADC frame packer and its DMA-side consumers:
// packing FSM encoding, pad marker and trailer field layout.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_OPEN_EVEN = 2'b01,
    ST_OPEN_ODD  = 2'b10
  } pack_state_e;

  // flags = 2'b01 in the upper half marks a padded final word
  localparam logic [31:0] PAD_WORD = 32'h4000_0000;

  localparam int TRL_TS_LSB  = 0;
  localparam int TRL_CNT_LSB = 32;
  localparam int TRL_ID_LSB  = 48;
  localparam int TRL_OVF_BIT = 63;

  function automatic logic [63:0] pack_trailer(input logic        ovf,
                                               input logic [14:0] frame_id,
                                               input logic [15:0] cnt,
                                               input logic [31:0] ts);
    logic [63:0] w;
    w = '0;
    w[TRL_TS_LSB +: 32]  = ts;
    w[TRL_CNT_LSB +: 16] = cnt;
    w[TRL_ID_LSB +: 15]  = frame_id;
    w[TRL_OVF_BIT]       = ovf;
    return w;
  endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// Sample-in / packed-word-out stream bundle of the ADC frame packer.
// The sample side has no back-pressure, hence no s_axis_tready.
interface adc_frame_packer_if;
  logic        s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head entry is always on rd_data_o.
// A write while full is accepted only if a read happens in the same cycle.
module sync_fifo_fwft #(
  parameter int W  = 65,
  parameter int AW = 9
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem_q [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_wr, do_rd;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == DEPTH);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = cnt_q;

  always_ff @(posedge aclk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_wr && !do_rd)      cnt_q <= cnt_q + 1'b1;
      else if (!do_wr && do_rd) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs 32-bit ADC samples pairwise into 64-bit words, closes frames on tlast
// or idle timeout, appends a trailer per frame and buffers all in a FWFT FIFO.
//
//   state        | meaning
//   ST_IDLE      | no frame open
//   ST_OPEN_EVEN | frame open, no half-word held
//   ST_OPEN_ODD  | frame open, one sample held as the low half
module adc_frame_packer
  import adc_pkg::*;
#(
  parameter int FIFO_AW      = 9,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  adc_frame_packer_if.slave  axis,
  input  logic [63:0]        cur_sample,
  input  logic               nreset_stats,
  output logic [31:0]        overflow_count,
  output logic [15:0]        frames_sent,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);

  pack_state_e state_q, state_d;
  logic [31:0] held_q, held_d;
  logic [31:0] ts_q, ts_d;
  logic [15:0] cnt_q, cnt_d, cnt_sat;
  logic [7:0]  idle_q, idle_d;
  logic        ovf_q, ovf_d;
  logic        tr_pend_q, tr_ovf_q;
  logic [15:0] tr_cnt_q;
  logic [31:0] tr_ts_q;
  logic [14:0] frame_id_q;
  logic [31:0] ovc_q;
  logic [15:0] fsent_q;

  logic        accept, close, data_we, trl_we, lost_trl, start;
  logic        wr_en, rd_fire, drop, fifo_full, fifo_empty;
  logic [63:0] data_word;
  logic [64:0] wr_data, rd_data;
  logic        unused_ts_hi;

  assign accept       = axis.s_axis_tvalid;
  assign cnt_sat      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign unused_ts_hi = ^cur_sample[63:32];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    ts_d      = ts_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    data_we   = 1'b0;
    data_word = '0;
    close     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ts_d   = cur_sample[31:0];
          cnt_d  = 16'd1;
          held_d = axis.s_axis_tdata;
          idle_d = '0;
          if (axis.s_axis_tlast) begin
            close     = 1'b1;
            data_we   = 1'b1;
            data_word = {PAD_WORD, axis.s_axis_tdata};
          end else begin
            state_d = ST_OPEN_ODD;
          end
        end
      end
      ST_OPEN_EVEN: begin
        if (accept) begin
          cnt_d  = cnt_sat;
          held_d = axis.s_axis_tdata;
          idle_d = '0;
          if (axis.s_axis_tlast) begin
            close     = 1'b1;
            data_we   = 1'b1;
            data_word = {PAD_WORD, axis.s_axis_tdata};
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_OPEN_ODD;
          end
        end else if (idle_q == IDLE_LAST) begin
          close   = 1'b1;
          idle_d  = '0;
          state_d = ST_IDLE;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      ST_OPEN_ODD: begin
        if (accept) begin
          cnt_d     = cnt_sat;
          idle_d    = '0;
          data_we   = 1'b1;
          data_word = {axis.s_axis_tdata, held_q};
          close     = axis.s_axis_tlast;
          state_d   = axis.s_axis_tlast ? ST_IDLE : ST_OPEN_EVEN;
        end else if (idle_q == IDLE_LAST) begin
          close     = 1'b1;
          data_we   = 1'b1;
          data_word = {PAD_WORD, held_q};
          idle_d    = '0;
          state_d   = ST_IDLE;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A close that lands while an older trailer is still blocked by a data word
  // drops the older trailer (counted as overflow) so the wait stays bounded.
  assign start    = accept && (state_q == ST_IDLE);
  assign trl_we   = tr_pend_q && !data_we;
  assign lost_trl = close && tr_pend_q && !trl_we;
  assign wr_en    = data_we || trl_we;
  assign wr_data  = data_we ? {1'b0, data_word}
                            : {1'b1, pack_trailer(tr_ovf_q, frame_id_q, tr_cnt_q, tr_ts_q)};
  assign rd_fire  = axis.m_axis_tready && !fifo_empty;
  assign drop     = wr_en && fifo_full && !rd_fire;
  assign ovf_d    = (start ? 1'b0 : ovf_q) | drop;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      held_q     <= '0;
      ts_q       <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      ovf_q      <= 1'b0;
      tr_pend_q  <= 1'b0;
      tr_ovf_q   <= 1'b0;
      tr_cnt_q   <= '0;
      tr_ts_q    <= '0;
      frame_id_q <= '0;
      ovc_q      <= '0;
      fsent_q    <= '0;
    end else begin
      held_q <= held_d;
      ts_q   <= ts_d;
      cnt_q  <= cnt_d;
      idle_q <= idle_d;
      ovf_q  <= ovf_d;
      if (close) begin
        tr_pend_q <= 1'b1;
        tr_ovf_q  <= ovf_d;
        tr_cnt_q  <= cnt_d;
        tr_ts_q   <= ts_d;
      end else if (trl_we) begin
        tr_pend_q <= 1'b0;
      end
      if (trl_we || lost_trl) frame_id_q <= frame_id_q + 15'd1;
      if (!nreset_stats) begin
        ovc_q   <= '0;
        fsent_q <= '0;
      end else begin
        ovc_q <= ovc_q + {31'd0, drop} + {31'd0, lost_trl};
        if (trl_we && !drop) fsent_q <= fsent_q + 16'd1;
      end
    end
  end

  sync_fifo_fwft #(
    .W  (65),
    .AW (FIFO_AW)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (axis.m_axis_tready),
    .rd_data_o (rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign axis.m_axis_tvalid = !fifo_empty;
  assign axis.m_axis_tdata  = rd_data[63:0];
  assign axis.m_axis_tlast  = rd_data[64];
  assign overflow_count     = ovc_q;
  assign frames_sent        = fsent_q;

endmodule

// File: doc/adc_frame_packer.md
ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

Interface
REQ-001 Parameter FIFO_AW, default 9, log2 of FIFO depth in 64-bit entries (512).
REQ-002 Parameter IDLE_TIMEOUT, default 16, number of consecutive s_axis_tvalid-low cycles that closes an open frame; legal range 2..255.
REQ-003 aclk  in  1  sole clock; all logic is on the rising edge.
REQ-004 aresetn  in  1  reset, asynchronous, active-low.
REQ-005 s_axis_tvalid  in  1  sample strobe from the ADC trigger stage; there is no tready, so a sample is accepted whenever tvalid=1.
REQ-006 s_axis_tdata  in  32  {flags[1:0], a[14:0], b[14:0]}.
REQ-007 s_axis_tlast  in  1  last sample of a series.
REQ-008 cur_sample  in  64  free-running sample counter used as the timestamp.
REQ-009 nreset_stats  in  1  synchronous active-low clear of the statistics outputs.
REQ-010 m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1 each  AXI-Stream master handshake toward the DMA writer.
REQ-011 m_axis_tdata  out  64  packed sample word or frame trailer.
REQ-012 overflow_count  out  32  number of FIFO words dropped because the FIFO was full.
REQ-013 frames_sent  out  16  number of trailers written into the FIFO.
REQ-014 fifo_level  out  FIFO_AW+1  current FIFO occupancy.

Function
REQ-015 The block SHALL implement a packing FSM with states IDLE (no frame open), OPEN_EVEN (frame open, no half-word held) and OPEN_ODD (frame open, one sample held).
REQ-016 On an accepted sample in IDLE, the block SHALL latch ts=cur_sample[31:0], clear cnt and ovf, hold the sample as the low half and go to OPEN_ODD.
REQ-017 On an accepted sample in OPEN_EVEN, the block SHALL hold the sample as the low half and go to OPEN_ODD.
REQ-018 On an accepted sample in OPEN_ODD, the block SHALL write {sample, held} (the first sample in bits [31:0]) to the FIFO in the same cycle and go to OPEN_EVEN.
REQ-019 cnt SHALL count the accepted samples of the frame and saturate at 16'hFFFF.
REQ-020 A frame SHALL close on an accepted sample with s_axis_tlast=1, or when the idle counter reaches IDLE_TIMEOUT in an OPEN state.
REQ-021 The idle counter SHALL increment on each tvalid-low cycle in an OPEN state and clear on any accepted sample.
REQ-022 When a frame closes with a half-word held, the block SHALL write the word {32'h4000_0000, held} in the closing cycle; flags 2'b01 mark the pad.
REQ-023 On close, the block SHALL set trailer_pending and return to IDLE.
REQ-024 The trailer word SHALL be {ovf, frame_id[14:0], cnt[15:0], ts[31:0]} and SHALL be tagged tlast=1 in the FIFO.
REQ-025 frame_id SHALL increment after each trailer write attempt and wrap from 0x7FFF to 0.
REQ-026 FIFO write priority SHALL be data word over trailer; a pending trailer SHALL write on the first cycle with no data write, and the wait SHALL be at most 1 cycle.
REQ-027 A tlast sample accepted in IDLE SHALL produce a one-sample frame: the pad word, then the trailer.
REQ-028 A write attempted while the FIFO is full SHALL be dropped, SHALL increment overflow_count and SHALL set ovf for the current frame; a dropped trailer SHALL still advance frame_id.
REQ-029 frames_sent SHALL count trailers actually written.
REQ-030 The FIFO SHALL be first-word-fall-through, with m_axis_tvalid equal to !empty and m_axis_tdata/m_axis_tlast taken from the head entry.
REQ-031 A word written at edge N into an empty FIFO SHALL be visible at the output at N+1.
REQ-032 A simultaneous read and write SHALL be allowed when the FIFO is full.
REQ-033 The output SHALL hold tdata/tlast stable while tvalid=1 and tready=0.
REQ-034 nreset_stats=0 SHALL zero overflow_count and frames_sent only; it SHALL have priority over a same-cycle increment.

Reset
REQ-035 aresetn=0 SHALL asynchronously force the FSM to IDLE and empty the FIFO.
REQ-036 aresetn=0 SHALL zero trailer_pending, idle counter, cnt, ovf, ts, frame_id, overflow_count, frames_sent, fifo_level and m_axis_tvalid.
REQ-037 An open frame at reset SHALL be discarded without a trailer.

Structure
REQ-038 The trailer field offsets, pad constant 32'h4000_0000 and FSM state encoding SHALL live in shared package adc_pkg.
REQ-039 The FIFO SHALL be a separate sub-module sync_fifo_fwft (width 65 = tlast+data, depth 2^FIFO_AW), reusable by the DMA writer.

Verification
REQ-040 4 samples S0..S3 with tlast on S3, tready=1, cur_sample=100 at S0 -> words {S1,S0}, {S3,S2}, then trailer {0,id0,cnt=4,ts=100} with tlast=1.
REQ-041 3 samples with tvalid then dropped low, no tlast -> after 16 idle cycles {pad,S2} is written, then trailer cnt=3 one cycle later.
REQ-042 tlast on S0, new series starting on the next cycle -> pad word, trailer and new-frame words appear in order, none lost, frames_sent=1.
REQ-043 tready=0 with 1200 contiguous samples -> fifo_level=512, overflow_count=88 (600-512), trailer ovf=1; release tready -> 512 words drained in order.
REQ-044 aresetn pulsed mid-frame -> all outputs zero, no trailer; a following 2-sample tlast frame yields frame_id=0.
REQ-045 nreset_stats=0 on the same cycle a trailer is written -> frames_sent reads 0.
